fc_output_streamer: RTL and testbench

FC_OUTPUT_STREAMER -- requirements
Module: fc_output_streamer

---
 rtl/fc_output_streamer.sv | 141 ++++++++++++++
 tb/tb_fc_output_streamer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_output_streamer.sv
// Captures a fully-connected layer result vector and streams it out one signed
// byte per handshake, tracking the argmax of each vector as it goes.
//
// state  | meaning
// IDLE   | no vector held, waiting for in_valid
// STREAM | presenting elements on m_*, advancing on each handshake
// DONE   | last element accepted; argmax pulse, may capture the next vector
module fc_output_streamer #(
    parameter int OUTPUT_SIZE = 10,
    parameter int IDX_W       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [OUTPUT_SIZE*8-1:0] in_vec,
    input  logic                     in_valid,
    output logic                     busy,
    output logic [7:0]               m_data,
    output logic [IDX_W-1:0]         m_index,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last,
    output logic [IDX_W-1:0]         argmax_idx,
    output logic [7:0]               argmax_val,
    output logic                     argmax_valid,
    output logic                     overrun,
    input  logic                     clr_overrun
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_SIZE - 1);

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_hold [OUTPUT_SIZE];
    logic [IDX_W-1:0] r_cnt;
    logic [7:0]       r_max_val;
    logic [IDX_W-1:0] r_max_idx;
    logic [7:0]       r_argmax_val;
    logic [IDX_W-1:0] r_argmax_idx;
    logic             r_overrun;

    logic             w_capture;
    logic             w_drop;
    logic             w_hs;
    logic             w_last_hs;
    logic [7:0]       w_elem;
    logic [7:0]       w_max_val;
    logic [IDX_W-1:0] w_max_idx;

    assign w_capture = in_valid && (r_state != S_STREAM);
    assign w_drop    = in_valid && (r_state == S_STREAM);
    assign w_hs      = (r_state == S_STREAM) && m_ready;
    assign w_last_hs = w_hs && (r_cnt == LAST_IDX);

    always_comb begin
        w_elem = 8'd0;
        for (int i = 0; i < OUTPUT_SIZE; i++) begin
            if (r_cnt == IDX_W'(i)) w_elem = r_hold[i];
        end
    end

    // Strictly-greater replacement keeps the lowest index on ties.
    always_comb begin
        w_max_val = r_max_val;
        w_max_idx = r_max_idx;
        if ((r_cnt == '0) || ($signed(w_elem) > $signed(r_max_val))) begin
            w_max_val = w_elem;
            w_max_idx = r_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        busy         = 1'b0;
        m_valid      = 1'b0;
        argmax_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) w_next = S_STREAM;
            end
            S_STREAM: begin
                busy    = 1'b1;
                m_valid = 1'b1;
                if (w_last_hs) w_next = S_DONE;
            end
            S_DONE: begin
                argmax_valid = 1'b1;
                w_next       = in_valid ? S_STREAM : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < OUTPUT_SIZE; i++) r_hold[i] <= 8'd0;
            r_cnt        <= '0;
            r_max_val    <= 8'd0;
            r_max_idx    <= '0;
            r_argmax_val <= 8'd0;
            r_argmax_idx <= '0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_capture) begin
                for (int i = 0; i < OUTPUT_SIZE; i++) r_hold[i] <= in_vec[i*8 +: 8];
                r_cnt <= '0;
            end else if (w_hs && !w_last_hs) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_hs) begin
                r_max_val <= w_max_val;
                r_max_idx <= w_max_idx;
            end
            // Loaded with the final element folded in, so values are valid during DONE.
            if (w_last_hs) begin
                r_argmax_val <= w_max_val;
                r_argmax_idx <= w_max_idx;
            end
            if (w_drop)           r_overrun <= 1'b1;
            else if (clr_overrun) r_overrun <= 1'b0;
        end
    end

    assign m_data     = m_valid ? w_elem : 8'd0;
    assign m_index    = m_valid ? r_cnt : '0;
    assign m_last     = m_valid && (r_cnt == LAST_IDX);
    assign argmax_idx = r_argmax_idx;
    assign argmax_val = r_argmax_val;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_fc_output_streamer.sv
// Self-checking bench for fc_output_streamer with a 4-element vector: directed
// cases plus randomized vectors and ready patterns against a reference argmax.
module tb_fc_output_streamer;

    localparam int N  = 4;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*8-1:0]  in_vec;
    logic            in_valid;
    logic            busy;
    logic [7:0]      m_data;
    logic [IW-1:0]   m_index;
    logic            m_valid;
    logic            m_ready;
    logic            m_last;
    logic [IW-1:0]   argmax_idx;
    logic [7:0]      argmax_val;
    logic            argmax_valid;
    logic            overrun;
    logic            clr_overrun;

    int total = 0;
    int bad   = 0;
    int exp_idx_g = 0;
    logic [7:0] exp_val_g = 8'd0;

    fc_output_streamer #(.OUTPUT_SIZE(N), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid), .busy(busy),
        .m_data(m_data), .m_index(m_index), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .argmax_idx(argmax_idx), .argmax_val(argmax_val),
        .argmax_valid(argmax_valid), .overrun(overrun), .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Largest signed element, earliest position wins ties.
    function automatic int ref_argmax(input logic [N*8-1:0] v);
        int b = 0;
        for (int i = 1; i < N; i++)
            if ($signed(v[i*8 +: 8]) > $signed(v[b*8 +: 8])) b = i;
        return b;
    endfunction

    task automatic check_reset_outputs(input string tag);
        total++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || m_last !== 1'b0 || argmax_valid !== 1'b0 ||
            overrun !== 1'b0 || m_data !== 8'd0 || m_index !== '0 ||
            argmax_idx !== '0 || argmax_val !== 8'd0) begin
            bad++;
            $display("FAIL %s: got v=%b b=%b l=%b av=%b ov=%b d=%h i=%0d ai=%0d aval=%h, expected all zero",
                     tag, m_valid, busy, m_last, argmax_valid, overrun, m_data, m_index,
                     argmax_idx, argmax_val);
        end
    endtask

    task automatic start(input logic [N*8-1:0] vec);
        in_vec   = vec;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Checks every presented element until the last handshake; ends in the DONE cycle.
    task automatic stream(input logic [N*8-1:0] vec, input logic [31:0] mask,
                          input int drop_at, input logic drop_clr);
        int   k = 0;
        int   c = 0;
        logic rdy;
        logic dropped = 1'b0;
        while (k < N && c < 100) begin
            rdy     = (c < 32) ? mask[c] : 1'b1;
            m_ready = rdy;
            total++;
            if (m_valid !== 1'b1 || busy !== 1'b1 || m_data !== vec[k*8 +: 8] ||
                m_index !== IW'(k) || m_last !== (k == N-1) || argmax_valid !== 1'b0) begin
                bad++;
                $display("FAIL stream elem %0d cyc %0d: got v=%b b=%b d=%h i=%0d l=%b av=%b, expected v=1 b=1 d=%h i=%0d l=%b av=0",
                         k, c, m_valid, busy, m_data, m_index, m_last, argmax_valid,
                         vec[k*8 +: 8], k, (k == N-1));
            end
            if (k == drop_at && !dropped) begin
                in_vec      = ~vec;
                in_valid    = 1'b1;
                clr_overrun = drop_clr;
                dropped     = 1'b1;
            end
            step();
            in_valid    = 1'b0;
            clr_overrun = 1'b0;
            if (rdy) k++;
            c++;
        end
        m_ready = 1'b0;
        total++;
        if (k < N) begin
            bad++;
            $display("FAIL stream timeout: got %0d elements, expected %0d", k, N);
        end
        exp_idx_g = ref_argmax(vec);
        exp_val_g = vec[exp_idx_g*8 +: 8];
        total++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || argmax_valid !== 1'b1 ||
            argmax_idx !== IW'(exp_idx_g) || argmax_val !== exp_val_g) begin
            bad++;
            $display("FAIL done cycle: got v=%b b=%b av=%b idx=%0d val=%h, expected v=0 b=0 av=1 idx=%0d val=%h",
                     m_valid, busy, argmax_valid, argmax_idx, argmax_val, exp_idx_g, exp_val_g);
        end
    endtask

    task automatic idle_check();
        step();
        total++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || argmax_valid !== 1'b0 ||
            argmax_idx !== IW'(exp_idx_g) || argmax_val !== exp_val_g) begin
            bad++;
            $display("FAIL idle hold: got v=%b b=%b av=%b idx=%0d val=%h, expected v=0 b=0 av=0 idx=%0d val=%h",
                     m_valid, busy, argmax_valid, argmax_idx, argmax_val, exp_idx_g, exp_val_g);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_vec = 32'h11223344;
        m_ready = 1'b1; clr_overrun = 1'b0;
        step();
        step();
        rst = 1'b0; in_valid = 1'b0;
        check_reset_outputs("reset state");
        start(32'h807FFE05);
        stream(32'h807FFE05, 32'hFFFF_FFFF, -1, 1'b0);
        idle_check();
    endtask

    task automatic test_ties();
        start(32'h03810303);
        stream(32'h03810303, 32'hFFFF_FFFF, -1, 1'b0);
        idle_check();
        start(32'h80808080);
        stream(32'h80808080, 32'hFFFF_FFFF, -1, 1'b0);
        idle_check();
    endtask

    task automatic test_backpressure();
        start(32'hC4017FAA);
        stream(32'hC4017FAA, 32'hFFFF_FFF1, -1, 1'b0);
        idle_check();
    endtask

    task automatic test_overrun();
        start(32'h10203040);
        stream(32'h10203040, 32'hFFFF_FFFF, 2, 1'b0);
        idle_check();
        step();
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun sticky: got %b expected 1", overrun);
        end
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun clear: got %b expected 0", overrun);
        end
        start(32'h05F0E0D0);
        stream(32'h05F0E0D0, 32'hFFFF_FFFF, 1, 1'b1);
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun set wins: got %b expected 1", overrun);
        end
        idle_check();
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
    endtask

    task automatic test_back_to_back();
        start(32'h01020304);
        stream(32'h01020304, 32'hFFFF_FFFF, -1, 1'b0);
        in_vec   = 32'h7F00FF81;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        stream(32'h7F00FF81, 32'h0000_5A5B, -1, 1'b0);
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL back_to_back overrun: got %b expected 0", overrun);
        end
        idle_check();
    endtask

    task automatic test_reset_midstream();
        start(32'h44332211);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        total++;
        if (m_valid !== 1'b1 || m_index !== IW'(1) || m_data !== 8'h22) begin
            bad++;
            $display("FAIL pre-reset elem1: got v=%b i=%0d d=%h expected v=1 i=1 d=22",
                     m_valid, m_index, m_data);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("reset midstream");
        step();
        check_reset_outputs("after reset idle");
        start(32'h9A8B7C6D);
        stream(32'h9A8B7C6D, 32'hFFFF_FFFF, -1, 1'b0);
        idle_check();
    endtask

    task automatic test_random();
        logic [N*8-1:0] vec;
        logic [7:0] pool [4];
        pool[0] = 8'h80; pool[1] = 8'h7F; pool[2] = 8'h00; pool[3] = 8'hFF;
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < N; i++)
                vec[i*8 +: 8] = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 3)]
                                                             : 8'($urandom);
            start(vec);
            stream(vec, $urandom, -1, 1'b0);
            idle_check();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_vec = '0; in_valid = 1'b0; m_ready = 1'b0; clr_overrun = 1'b0;
        test_reset();
        test_ties();
        test_backpressure();
        test_overrun();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
